// File: rtl/mod_additive_synth.sv
// Additive synthesiser: N sine partials (octave or harmonic series) summed through one shared LUT and multiplier.
// One frame per accepted tick, o_valid N_PARTIALS+3 cycles after it; ticks while busy are dropped and flagged.

module mod_additive_synth #(
  parameter int N_PARTIALS = 8,
  parameter int PHASE_W    = 32,
  parameter int LUT_AW     = 10,
  parameter int OUT_W      = 32,
  localparam int AW        = (N_PARTIALS > 1) ? $clog2(N_PARTIALS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_sample_tick,
  input  logic [PHASE_W-1:0]        i_phase_inc,
  input  logic                      i_mode,
  input  logic                      i_gain_we,
  input  logic [AW-1:0]             i_gain_addr,
  input  logic signed [15:0]        i_gain_data,
  input  logic signed [15:0]        i_atten_out,
  output logic signed [OUT_W-1:0]   o_sound,
  output logic                      o_valid,
  output logic                      o_busy,
  output logic                      o_overrun
);

  localparam int  ACC_W     = 32 + $clog2(N_PARTIALS);
  localparam int  YW        = ACC_W + 16;
  localparam int  LUT_DEPTH = 1 << LUT_AW;
  localparam real TWO_PI    = 6.283185307179586;
  localparam logic signed [YW-1:0] SAT_MAX = {{(YW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [YW-1:0] SAT_MIN = {{(YW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

  state_t                    state_q, state_d;
  logic [AW-1:0]             cnt_q, cnt_d;
  logic [PHASE_W-1:0]        phase_q [N_PARTIALS];
  logic signed [15:0]        gain_q  [N_PARTIALS];
  logic [PHASE_W-1:0]        inc_q, step_q, step_d, phase_sum;
  logic                      mode_q;
  logic signed [15:0]        lut [LUT_DEPTH];
  logic signed [15:0]        sine_q, gain_rd_q;
  logic                      pipe_vld_q;
  logic signed [31:0]        prod_full;
  logic signed [ACC_W-1:0]   prod, acc_q;
  logic signed [YW-1:0]      y_full, y_sh;
  logic signed [OUT_W-1:0]   sound_q, sound_d;
  logic                      overrun_q;
  logic                      start, load_out;

  // Full-wave sine table, rounded to nearest, built at elaboration.
  for (genvar i = 0; i < LUT_DEPTH; i++) begin : g_lut
    localparam real X = 32767.0 * $sin(TWO_PI * real'(i) / real'(LUT_DEPTH));
    localparam int  V = (X >= 0.0) ? $rtoi(X + 0.5) : -$rtoi(0.5 - X);
    assign lut[i] = 16'(V);
  end

  assign start     = (state_q == S_IDLE) && i_sample_tick;
  assign load_out  = (state_q == S_DRAIN) && (cnt_q == AW'(1));
  assign phase_sum = phase_q[cnt_q] + step_q;
  // Partial increments are generated incrementally: doubling for octaves, adding inc for harmonics.
  assign step_d    = mode_q ? (step_q + inc_q) : (step_q << 1);
  assign prod_full = 32'(sine_q) * 32'(gain_rd_q);
  assign prod      = ACC_W'(prod_full >>> 15);
  assign y_full    = YW'(acc_q) * YW'(i_atten_out);
  assign y_sh      = y_full >>> 15;

  always_comb begin
    sound_d = y_sh[OUT_W-1:0];
    if (y_sh > SAT_MAX) begin
      sound_d = SAT_MAX[OUT_W-1:0];
    end else if (y_sh < SAT_MIN) begin
      sound_d = SAT_MIN[OUT_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_sample_tick) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q == AW'(N_PARTIALS - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == AW'(1)) begin
          state_d = S_OUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < N_PARTIALS; k++) begin
        phase_q[k] <= '0;
        gain_q[k]  <= '0;
      end
      inc_q      <= '0;
      step_q     <= '0;
      mode_q     <= 1'b0;
      sine_q     <= '0;
      gain_rd_q  <= '0;
      pipe_vld_q <= 1'b0;
      acc_q      <= '0;
      sound_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      for (int k = 0; k < N_PARTIALS; k++) begin
        if (i_gain_we && (i_gain_addr == AW'(k))) begin
          gain_q[k] <= i_gain_data;
        end
        if ((state_q == S_RUN) && (cnt_q == AW'(k))) begin
          phase_q[k] <= phase_sum;
        end
      end
      if (start) begin
        inc_q  <= i_phase_inc;
        step_q <= i_phase_inc;
        mode_q <= i_mode;
        acc_q  <= '0;
      end
      if (i_sample_tick && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end
      if (state_q == S_RUN) begin
        step_q    <= step_d;
        sine_q    <= lut[phase_sum[PHASE_W-1 -: LUT_AW]];
        gain_rd_q <= gain_q[cnt_q];
      end
      pipe_vld_q <= (state_q == S_RUN);
      if (pipe_vld_q) begin
        acc_q <= acc_q + prod;
      end
      if (load_out) begin
        sound_q <= sound_d;
      end
    end
  end

  assign o_sound   = sound_q;
  assign o_valid   = (state_q == S_OUT);
  assign o_busy    = (state_q != S_IDLE);
  assign o_overrun = overrun_q;

endmodule
